// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: CPU-side byte FIFO in front of a polled uart transmitter.
// The CPU pushes bytes through the data register (addr=0). The status/control
// register (addr=1) reports {full, ovf, empty, count}. A read of this register
// clears the overflow flag. Writing it with dbw[0]=1 flushes the FIFO.
// A small FSM polls the uart busy bit and forwards one byte per write strobe.
// Each write is followed by a guard interval before the next poll.

module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GUARD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dbw,
  output logic [7:0] dbr,
  input  logic       addr,
  input  logic       cs,
  input  logic       we,
  output logic [7:0] u_dbw,
  input  logic [7:0] u_dbr,
  output logic       u_addr,
  output logic       u_we
);

  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  FULL_CNT   = 5'(DEPTH);
  localparam logic [3:0]  GUARD_LAST = 4'(GUARD - 1);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two in 2..16");
  end
  if (GUARD < 1 || GUARD > 15) begin : g_bad_guard
    $error("uart_tx_fifo: GUARD must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_POLL,
    S_SEND,
    S_GUARD
  } state_t;

  // Storage and FIFO bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;

  // Transmit FSM
  state_t        state_q, state_d;
  logic [3:0]    gcnt_q, gcnt_d;
  logic          u_we_q, u_we_d;
  logic          u_addr_q, u_addr_d;

  // Decoded CPU accesses and FIFO events
  logic push, flush, ovf_clr;
  logic empty, full;
  logic pop, push_ok, drop;

  // Only the busy bit of the uart status is meaningful here
  logic unused_u_dbr;
  assign unused_u_dbr = ^u_dbr[6:0];

  // Decode the CPU access and derive this cycle's push/pop/drop events
  always_comb begin
    push    = cs & we & ~addr;
    flush   = cs & we & addr & dbw[0];
    ovf_clr = cs & ~we & addr;
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    // A flush discards the pop that SEND would otherwise perform
    pop     = (state_q == S_SEND) & ~empty & ~flush;
    // A push into a full FIFO still fits when the head leaves at the same edge
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;
  end

  // Next pointers, occupancy and sticky overflow
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      if (push_ok && !pop) begin
        count_d = count_q + 5'd1;
      end else if (pop && !push_ok) begin
        count_d = count_q - 5'd1;
      end
    end
    // A drop in the same cycle as a status read keeps the flag set
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Byte storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem_q[wptr_q] <= dbw;
    end
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state of the poll/send/guard sequencer and its registered strobes
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        // A flush in this cycle leaves nothing to send
        if (empty || flush) begin
          state_d = S_IDLE;
        end else if (!u_dbr[7]) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_GUARD;
        gcnt_d  = GUARD_LAST;
      end
      S_GUARD: begin
        if (gcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    u_we_d   = (state_d == S_SEND);
    u_addr_d = (state_d == S_POLL);
  end

  // Sequencer registers; strobes are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gcnt_q   <= '0;
      u_we_q   <= 1'b0;
      u_addr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      u_we_q   <= u_we_d;
      u_addr_q <= u_addr_d;
    end
  end

  // Output drive; strobes are forced low while reset is held
  always_comb begin
    u_we   = u_we_q & ~rst;
    u_addr = u_addr_q & ~rst;
    u_dbw  = mem_q[rptr_q];
    dbr    = addr ? {full, ovf_q, empty, count_q} : 8'h00;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios followed by a randomized run.
// The randomized run is checked against a queue-based model of the FIFO.

module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned GUARD = 2;

  logic       clk;
  logic       rst;
  logic [7:0] dbw;
  logic [7:0] dbr;
  logic       addr;
  logic       cs;
  logic       we;
  logic [7:0] u_dbw;
  logic [7:0] u_dbr;
  logic       u_addr;
  logic       u_we;

  int n_cmp;
  int n_bad;

  logic [7:0] sent_q[$];
  logic [7:0] mq[$];
  logic       mdl_ovf;

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .GUARD(GUARD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .dbw   (dbw),
    .dbr   (dbr),
    .addr  (addr),
    .cs    (cs),
    .we    (we),
    .u_dbw (u_dbw),
    .u_dbr (u_dbr),
    .u_addr(u_addr),
    .u_we  (u_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; log every uart write strobe seen in the new cycle
  task automatic tick();
    @(posedge clk);
    #2;
    if (u_we === 1'b1) sent_q.push_back(u_dbw);
  endtask

  task automatic cpu_push(input logic [7:0] b);
    cs = 1'b1; we = 1'b1; addr = 1'b0; dbw = b;
    tick();
    cs = 1'b0; we = 1'b0; dbw = 8'h00;
  endtask

  task automatic cpu_flush();
    cs = 1'b1; we = 1'b1; addr = 1'b1; dbw = 8'h01;
    tick();
    cs = 1'b0; we = 1'b0; addr = 1'b0; dbw = 8'h00;
  endtask

  task automatic peek_status(input string tag, input logic [7:0] exp);
    addr = 1'b1;
    #1;
    chk(tag, dbr, exp);
    addr = 1'b0;
    #1;
  endtask

  task automatic cpu_rd_status(input string tag, input logic [7:0] exp);
    cs = 1'b1; we = 1'b0; addr = 1'b1;
    #1;
    chk(tag, dbr, exp);
    tick();
    cs = 1'b0; addr = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget);
    for (int i = 0; i < budget && sent_q.size() < n; i++) tick();
  endtask

  function automatic logic [7:0] mdl_status();
    return {mq.size() == DEPTH, mdl_ovf, mq.size() == 0, 5'(mq.size())};
  endfunction

  initial begin
    logic [7:0] exp_b;
    logic       prev_addr;
    logic       prev_busy;
    logic       do_push, do_rd, do_flush, do_wr1;
    logic       pop;
    int         r;

    n_cmp = 0; n_bad = 0;
    rst = 1'b1; dbw = 8'h00; addr = 1'b0; cs = 1'b0; we = 1'b0; u_dbr = 8'h00;

    // Reset state
    tick();
    chk("rst_we", u_we, 1'b0);
    chk("rst_addr", u_addr, 1'b0);
    peek_status("rst_status", 8'h20);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_we", u_we, 1'b0);
    chk("post_rst_addr", u_addr, 1'b0);
    peek_status("post_rst_status", 8'h20);
    #1;
    chk("dbr_data_reg", dbr, 8'h00);

    // First-byte latency and guard spacing
    u_dbr = 8'h00;
    cpu_push(8'h7B);
    chk("lat_c1_we", u_we, 1'b0);
    tick();
    chk("lat_c2_we", u_we, 1'b0);
    chk("lat_c2_addr", u_addr, 1'b1);
    tick();
    chk("lat_c3_we", u_we, 1'b1);
    chk("lat_c3_dbw", u_dbw, 8'h7B);
    chk("lat_c3_addr", u_addr, 1'b0);
    tick();
    chk("guard1_we", u_we, 1'b0);
    peek_status("after_send_status", 8'h20);
    cpu_push(8'h11);
    chk("guard2_we", u_we, 1'b0);
    tick();
    chk("idle_we", u_we, 1'b0);
    tick();
    chk("poll2_we", u_we, 1'b0);
    chk("poll2_addr", u_addr, 1'b1);
    tick();
    chk("send2_we", u_we, 1'b1);
    chk("send2_dbw", u_dbw, 8'h11);
    repeat (4) tick();

    // Busy uart holds the byte in POLL
    u_dbr = 8'h80;
    cpu_push(8'h3E);
    tick();
    for (int i = 0; i < 50; i++) begin
      chk("busy_we", u_we, 1'b0);
      chk("busy_addr", u_addr, 1'b1);
      tick();
    end
    u_dbr = 8'h00;
    #1;
    chk("busy_clear_we", u_we, 1'b0);
    tick();
    chk("busy_send_we", u_we, 1'b1);
    chk("busy_send_dbw", u_dbw, 8'h3E);
    repeat (4) tick();

    // Overflow: 17 pushes against a stalled uart
    u_dbr = 8'h80;
    for (int i = 1; i <= 17; i++) cpu_push(8'(i));
    peek_status("ovf_status", 8'hD0);
    cpu_rd_status("ovf_rd_status", 8'hD0);
    peek_status("ovf_cleared_status", 8'h90);
    sent_q.delete();
    u_dbr = 8'h00;
    wait_sent(16, 200);
    repeat (12) tick();
    chk("ovf_drain_count", 8'(sent_q.size()), 8'd16);
    for (int i = 0; i < 16; i++) chk("ovf_drain_byte", sent_q[i], 8'(i + 1));
    peek_status("ovf_drained_status", 8'h20);

    // Flush with bytes queued, landing while GUARD runs
    sent_q.delete();
    for (int i = 0; i < 5; i++) cpu_push(8'hA0 + 8'(i));
    cpu_flush();
    peek_status("flush_status", 8'h20);
    repeat (20) tick();
    chk("flush_sent_count", 8'(sent_q.size()), 8'd1);
    chk("flush_sent_byte", sent_q[0], 8'hA0);

    // Push into a full FIFO in the same cycle as a SEND pop
    u_dbr = 8'h80;
    sent_q.delete();
    for (int i = 0; i < 16; i++) cpu_push(8'h40 + 8'(i));
    peek_status("full_status", 8'h90);
    u_dbr = 8'h00;
    tick();
    chk("full_send_we", u_we, 1'b1);
    cpu_push(8'h99);
    peek_status("full_pushpop_status", 8'h90);
    wait_sent(17, 300);
    repeat (12) tick();
    chk("full_sent_count", 8'(sent_q.size()), 8'd17);
    for (int i = 0; i < 16; i++) chk("full_sent_byte", sent_q[i], 8'h40 + 8'(i));
    chk("full_sent_last", sent_q[16], 8'h99);

    // Reset pulse during POLL with bytes queued
    u_dbr = 8'h80;
    for (int i = 0; i < 3; i++) cpu_push(8'h61 + 8'(i));
    chk("rstmid_poll_addr", u_addr, 1'b1);
    sent_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    peek_status("rstmid_status", 8'h20);
    chk("rstmid_we", u_we, 1'b0);
    chk("rstmid_addr", u_addr, 1'b0);
    u_dbr = 8'h00;
    tick();
    chk("rstmid_next_we", u_we, 1'b0);
    chk("rstmid_next_addr", u_addr, 1'b0);
    repeat (10) tick();
    chk("rstmid_sent_count", 8'(sent_q.size()), 8'd0);

    // Randomized traffic against the queue model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    mq.delete();
    mdl_ovf = 1'b0;
    prev_addr = 1'b0;
    prev_busy = 1'b1;
    for (int c = 0; c < 600; c++) begin
      r        = int'($urandom_range(0, 99));
      do_push  = (r < 45);
      do_rd    = (r >= 45 && r < 55);
      do_flush = (r >= 55 && r < 58);
      do_wr1   = (r >= 58 && r < 61);
      u_dbr    = {($urandom_range(0, 99) < 30), 7'($urandom)};
      cs       = do_push | do_rd | do_flush | do_wr1;
      we       = do_push | do_flush | do_wr1;
      addr     = ~do_push;
      dbw      = 8'($urandom);
      if (do_flush) dbw[0] = 1'b1;
      if (do_wr1) dbw[0] = 1'b0;
      #1;
      if (!do_push) chk("rnd_status", dbr, mdl_status());
      pop = (u_we === 1'b1);
      if (pop) begin
        exp_b = (mq.size() > 0) ? mq[0] : 8'hxx;
        chk("rnd_send_dbw", u_dbw, exp_b);
        chk("rnd_send_after_poll", {6'd0, prev_addr, prev_busy}, 8'h02);
      end
      if (do_flush) begin
        mq.delete();
      end else begin
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (do_push) begin
          if (mq.size() < DEPTH) mq.push_back(dbw);
          else mdl_ovf = 1'b1;
        end
      end
      if (do_rd) mdl_ovf = 1'b0;
      prev_addr = u_addr;
      prev_busy = u_dbr[7];
      tick();
    end
    cs = 1'b0; we = 1'b0; addr = 1'b1; u_dbr = 8'h00;
    for (int i = 0; i < 300 && mq.size() > 0; i++) begin
      #1;
      if (u_we === 1'b1) begin
        chk("rnd_drain_dbw", u_dbw, mq[0]);
        void'(mq.pop_front());
      end
      tick();
    end
    chk("rnd_drain_left", 8'(mq.size()), 8'd0);
    repeat (8) tick();
    #1;
    chk("rnd_final_status", dbr, mdl_status());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
